// File: rtl/lutram_pkt_fifo.sv
// Single-clock FWFT FIFO on distributed RAM with commit-on-last packet mode,
// packet abort, overflow auto-drop and runtime almost-full/almost-empty thresholds.
module lutram_pkt_fifo #(
    parameter int    FIFO_DEPTH = 32,
    parameter int    DATA_WIDTH = 32,
    parameter string PKT_MODE   = "true",
    parameter int    SIM_DELAY  = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          s_wen,
    input  logic [DATA_WIDTH-1:0]         s_din,
    input  logic                          s_last,
    input  logic                          s_drop,
    output logic                          s_full,
    output logic                          s_almost_full,
    output logic                          s_overflow_drop,
    input  logic                          m_ren,
    output logic [DATA_WIDTH-1:0]         m_dout,
    output logic                          m_last,
    output logic                          m_empty,
    output logic                          m_almost_empty,
    input  logic [$clog2(FIFO_DEPTH):0]   cfg_af_th,
    input  logic [$clog2(FIFO_DEPTH):0]   cfg_ae_th,
    output logic [$clog2(FIFO_DEPTH):0]   data_cnt,
    output logic [$clog2(FIFO_DEPTH):0]   pkt_cnt
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int PW = AW + 1;
    localparam bit PKT_EN = (PKT_MODE == "true");
    localparam logic [PW-1:0] DEPTH_P = PW'(FIFO_DEPTH);
    localparam logic [PW-1:0] ONE_P   = PW'(1);

    if (FIFO_DEPTH < 4 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || SIM_DELAY < 0) begin : g_param_err
        $error("lutram_pkt_fifo: illegal parameter set");
    end

    logic [DATA_WIDTH:0] mem_r [FIFO_DEPTH];

    logic [PW-1:0] wptr_r, cptr_r, rptr_r, pkt_cnt_r;
    logic [PW-1:0] wptr_s, cptr_s, rptr_s, pkt_cnt_s;
    logic          dul_r, dul_s;
    logic          ovf_r;

    logic [PW-1:0] occ_s, com_s;
    logic          full_s, empty_s, head_last_s;
    logic          drop_s, discard_s, ovf_s, wr_acc_s, commit_s, rd_acc_s;
    logic          pkt_inc_s, pkt_dec_s;

    assign occ_s       = wptr_r - rptr_r;
    assign com_s       = cptr_r - rptr_r;
    assign full_s      = (occ_s == DEPTH_P);
    assign empty_s     = (cptr_r == rptr_r);
    assign head_last_s = mem_r[rptr_r[AW-1:0]][DATA_WIDTH];

    // A single open packet filling the whole FIFO can never commit, so it is dropped
    assign drop_s    = PKT_EN & s_drop;
    assign discard_s = PKT_EN & dul_r & s_wen & ~drop_s;
    assign ovf_s     = PKT_EN & s_wen & ~drop_s & ~dul_r & full_s & empty_s;
    assign wr_acc_s  = s_wen & ~full_s & ~drop_s & ~discard_s;
    assign commit_s  = wr_acc_s & (s_last | ~PKT_EN);
    assign rd_acc_s  = m_ren & ~empty_s;
    assign pkt_inc_s = commit_s & s_last;
    assign pkt_dec_s = rd_acc_s & head_last_s;

    // Next-state computation for pointers, packet counter and drop-until-last flag
    always_comb begin
        wptr_s    = wptr_r;
        cptr_s    = cptr_r;
        rptr_s    = rptr_r;
        pkt_cnt_s = pkt_cnt_r;
        dul_s     = dul_r;

        if (drop_s || ovf_s) begin
            wptr_s = cptr_r;
        end else if (wr_acc_s) begin
            wptr_s = wptr_r + ONE_P;
        end else begin
            wptr_s = wptr_r;
        end

        if (commit_s) begin
            cptr_s = wptr_r + ONE_P;
        end else begin
            cptr_s = cptr_r;
        end

        if (rd_acc_s) begin
            rptr_s = rptr_r + ONE_P;
        end else begin
            rptr_s = rptr_r;
        end

        case ({pkt_inc_s, pkt_dec_s})
            2'b10:   pkt_cnt_s = pkt_cnt_r + ONE_P;
            2'b01:   pkt_cnt_s = pkt_cnt_r - ONE_P;
            default: pkt_cnt_s = pkt_cnt_r;
        endcase

        if (ovf_s) begin
            dul_s = ~s_last;
        end else if (discard_s && s_last) begin
            dul_s = 1'b0;
        end else begin
            dul_s = dul_r;
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_r    <= {PW{1'b0}};
            cptr_r    <= {PW{1'b0}};
            rptr_r    <= {PW{1'b0}};
            pkt_cnt_r <= {PW{1'b0}};
            dul_r     <= 1'b0;
            ovf_r     <= 1'b0;
        end else begin
            wptr_r    <= wptr_s;
            cptr_r    <= cptr_s;
            rptr_r    <= rptr_s;
            pkt_cnt_r <= pkt_cnt_s;
            dul_r     <= dul_s;
            ovf_r     <= ovf_s;
        end
    end

    // Storage array, left unreset so it maps onto distributed RAM
    always_ff @(posedge clk) begin
        if (wr_acc_s) begin
            mem_r[wptr_r[AW-1:0]] <= {s_last, s_din};
        end
    end

    assign m_dout          = mem_r[rptr_r[AW-1:0]][DATA_WIDTH-1:0];
    assign m_last          = head_last_s;
    assign m_empty         = empty_s;
    assign s_full          = full_s;
    assign s_almost_full   = (occ_s >= cfg_af_th);
    assign m_almost_empty  = (com_s <= cfg_ae_th);
    assign s_overflow_drop = ovf_r;
    assign data_cnt        = occ_s;
    assign pkt_cnt         = pkt_cnt_r;

endmodule

// File: tb/tb_lutram_pkt_fifo.sv
// Scoreboarded random + directed bench for lutram_pkt_fifo (packet mode, depth 8);
// reference model tracks committed and open words as plain queues.
module tb_lutram_pkt_fifo;

    localparam int D  = 8;
    localparam int W  = 32;
    localparam int PW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          s_wen, s_last, s_drop, m_ren;
    logic [W-1:0]  s_din;
    logic          s_full, s_almost_full, s_overflow_drop;
    logic [W-1:0]  m_dout;
    logic          m_last, m_empty, m_almost_empty;
    logic [PW-1:0] cfg_af_th, cfg_ae_th, data_cnt, pkt_cnt;

    always #5 clk = ~clk;

    lutram_pkt_fifo #(
        .FIFO_DEPTH(D), .DATA_WIDTH(W), .PKT_MODE("true"), .SIM_DELAY(1)
    ) dut (
        .clk(clk), .rst(rst),
        .s_wen(s_wen), .s_din(s_din), .s_last(s_last), .s_drop(s_drop),
        .s_full(s_full), .s_almost_full(s_almost_full), .s_overflow_drop(s_overflow_drop),
        .m_ren(m_ren), .m_dout(m_dout), .m_last(m_last), .m_empty(m_empty),
        .m_almost_empty(m_almost_empty), .cfg_af_th(cfg_af_th), .cfg_ae_th(cfg_ae_th),
        .data_cnt(data_cnt), .pkt_cnt(pkt_cnt)
    );

    logic [W:0] mdl_q[$];
    logic [W:0] open_q[$];
    logic [W:0] exp_q[$];
    bit         dul_m;
    bit         ovf_m;
    int         checks = 0;
    int         errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: one clock edge of FIFO behaviour at word/packet level
    task automatic model_step(input bit wen, input bit last, input bit drop, input bit ren,
                              input logic [W-1:0] din);
        bit full, emp;
        full  = (mdl_q.size() + open_q.size()) == D;
        emp   = (mdl_q.size() == 0);
        ovf_m = 1'b0;
        if (ren && !emp) void'(mdl_q.pop_front());
        if (drop) begin
            open_q.delete();
        end else if (dul_m) begin
            if (wen && last) dul_m = 1'b0;
        end else if (wen && !full) begin
            open_q.push_back({last, din});
            if (last) begin
                foreach (open_q[i]) begin
                    mdl_q.push_back(open_q[i]);
                    exp_q.push_back(open_q[i]);
                end
                open_q.delete();
            end
        end else if (wen && full && emp) begin
            open_q.delete();
            ovf_m = 1'b1;
            dul_m = !last;
        end
    endtask

    task automatic check_state();
        int occ, com, np;
        occ = mdl_q.size() + open_q.size();
        com = mdl_q.size();
        np  = 0;
        foreach (mdl_q[i]) if (mdl_q[i][W]) np++;
        chk("m_empty", m_empty, com == 0);
        chk("s_full", s_full, occ == D);
        chk("data_cnt", data_cnt, occ);
        chk("pkt_cnt", pkt_cnt, np);
        chk("s_almost_full", s_almost_full, occ >= int'(cfg_af_th));
        chk("m_almost_empty", m_almost_empty, com <= int'(cfg_ae_th));
        chk("s_overflow_drop", s_overflow_drop, ovf_m);
        if (com != 0) chk("head", {m_last, m_dout}, mdl_q[0]);
    endtask

    task automatic cyc(input bit wen, input bit last, input bit drop, input bit ren,
                       input logic [W-1:0] din);
        s_wen = wen; s_last = last; s_drop = drop; m_ren = ren; s_din = din;
        @(posedge clk);
        model_step(wen, last, drop, ren, din);
        #1;
        check_state();
    endtask

    task automatic do_reset();
        rst = 1'b1; s_wen = 1'b0; s_last = 1'b0; s_drop = 1'b0; m_ren = 1'b0; s_din = '0;
        @(posedge clk);
        mdl_q.delete(); open_q.delete(); exp_q.delete();
        dul_m = 1'b0; ovf_m = 1'b0;
        #1;
        check_state();
        rst = 1'b0;
    endtask

    // Scoreboard monitor: every accepted pop must match the oldest committed word
    always @(negedge clk) begin
        if (!rst && m_ren && !m_empty) begin
            if (exp_q.size() == 0) begin
                chk("rd_unexpected", 1, 0);
            end else begin
                chk("rd_data", {m_last, m_dout}, exp_q.pop_front());
            end
        end
    end

    initial begin
        cfg_af_th = PW'(6);
        cfg_ae_th = PW'(2);
        do_reset();
        do_reset();

        // single 3-word packet, then read it back
        for (int i = 0; i < 3; i++) cyc(1, i == 2, 0, 0, 32'hD000_0000 + i);
        cyc(0, 0, 0, 0, '0);
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 1, '0);
        cyc(0, 0, 0, 1, '0);

        // partial packet abort, then a clean 2-word packet
        cyc(1, 0, 0, 0, 32'hBAD0_0001);
        cyc(1, 0, 0, 0, 32'hBAD0_0002);
        cyc(1, 1, 1, 0, 32'hBAD0_0003);
        cyc(1, 0, 0, 0, 32'h0000_00AA);
        cyc(1, 1, 0, 0, 32'h0000_00BB);
        cyc(0, 0, 0, 1, '0);
        cyc(0, 0, 0, 1, '0);

        // oversize packet: fill, overflow auto-drop, discard rest, then packet X
        for (int i = 0; i < D; i++) cyc(1, 0, 0, 0, 32'h0F00_0000 + i);
        cyc(1, 0, 0, 0, 32'h0F00_0100);
        cyc(1, 0, 0, 0, 32'h0F00_0101);
        cyc(1, 1, 0, 0, 32'h0F00_0102);
        cyc(1, 1, 0, 0, 32'h0000_0C0C);
        cyc(0, 0, 0, 1, '0);

        // thresholds: fill to 7, read down
        cfg_af_th = PW'(6);
        cfg_ae_th = PW'(2);
        for (int i = 0; i < 7; i++) cyc(1, 1, 0, 0, $urandom);
        for (int i = 0; i < 8; i++) cyc(0, 0, 0, 1, '0);

        // steady state at 4 entries with wrap-around
        for (int i = 0; i < 4; i++) cyc(1, 1, 0, 0, $urandom);
        for (int i = 0; i < 20; i++) cyc(1, 1, 0, 1, $urandom);
        for (int i = 0; i < 4; i++) cyc(0, 0, 0, 1, '0);

        // reset with 5 committed words and an open packet
        for (int i = 0; i < 5; i++) cyc(1, 1, 0, 0, $urandom);
        cyc(1, 0, 0, 0, $urandom);
        cyc(1, 0, 0, 0, $urandom);
        do_reset();
        cyc(1, 0, 0, 0, 32'h1234_5678);
        cyc(1, 1, 0, 0, 32'h9ABC_DEF0);
        cyc(0, 0, 0, 1, '0);
        cyc(0, 0, 0, 1, '0);

        // randomized traffic with occasional threshold changes
        for (int i = 0; i < 2000; i++) begin
            if (i % 50 == 0) begin
                cfg_af_th = PW'($urandom_range(1, D));
                cfg_ae_th = PW'($urandom_range(0, D - 1));
            end
            cyc($urandom_range(0, 99) < 60, $urandom_range(0, 99) < 25,
                $urandom_range(0, 99) < 4, $urandom_range(0, 99) < 50, $urandom);
        end

        for (int i = 0; i < 3 * D; i++) cyc(0, 0, 0, 1, '0);
        chk("drain_left", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
